// File: rtl/multi_cycle_control.sv
// multi_cycle_control
//   Multi-cycle datapath controller. The opcode is decoded in DECODE and each
//   instruction class then walks through its own short chain of states.
//   Outputs are decoded from the registered state. In DECODE, MEM_ADDR,
//   BRANCH and I_EXEC the opcode selects the flavour of those outputs. The
//   opcode is held stable for the whole instruction, so this selection is
//   safe.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset; all outputs are 0 while high
//   OP[5:0]        opcode field
//   Funct[5:0]     function field, meaningful only when OP = 0x00
//   IRWrite .. IllegalOp   1-bit datapath strobes and selects
//   ALUSrcB[1:0]   ALU B operand select
//   PCSource[1:0]  next-PC select
//   ALUOp[3:0]     operation code for the ALU control stage
//   State[3:0]     current state code (debug)
//
// State table
//   code | state     | meaning
//   0    | FETCH     | read instruction, PC <= PC + 4
//   1    | DECODE    | register read, compute branch target, dispatch on OP
//   2    | MEM_ADDR  | compute effective address for LW/SW
//   3    | MEM_READ  | read data memory
//   4    | MEM_WB    | write load data to rt
//   5    | MEM_WRITE | write data memory
//   6    | R_EXEC    | R-type ALU operation
//   7    | R_WB      | write ALU result to rd
//   8    | BRANCH    | BEQ/BNE compare and conditional PC write
//   9    | JUMP      | PC <= jump target
//   10   | I_EXEC    | immediate ALU operation
//   11   | I_WB      | write ALU result to rt
//   12   | JR        | PC <= rs
//   13-15| (illegal) | recover to FETCH

module multi_cycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       IllegalOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_I_EXEC    = 4'd10;
  localparam logic [3:0] S_I_WB      = 4'd11;
  localparam logic [3:0] S_JR        = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [3:0] state;
  logic [3:0] state_next;
  logic [3:0] dispatch;
  logic       op_illegal;

  // Dispatch target out of DECODE. An unknown opcode returns to FETCH and
  // is flagged through IllegalOp.
  always_comb begin
    dispatch   = S_FETCH;
    op_illegal = 1'b0;
    case (OP)
      OP_LW, OP_SW:                   dispatch = S_MEM_ADDR;
      OP_RTYPE:                       dispatch = (Funct == FN_JR) ? S_JR : S_R_EXEC;
      OP_BEQ, OP_BNE:                 dispatch = S_BRANCH;
      OP_J:                           dispatch = S_JUMP;
      OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: dispatch = S_I_EXEC;
      default:                        op_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:     state_next = S_DECODE;
      S_DECODE:    state_next = dispatch;
      S_MEM_ADDR:  state_next = (OP == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_next = S_MEM_WB;
      S_R_EXEC:    state_next = S_R_WB;
      S_I_EXEC:    state_next = S_I_WB;
      default:     state_next = S_FETCH;
    endcase
  end

  // Everything is held at 0 while reset is high. This keeps an instruction
  // interrupted by reset from issuing any PC, register or memory write.
  always_comb begin
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    IllegalOp     = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALUOp         = 4'b0000;
    State         = 4'd0;
    if (!reset) begin
      State = state;
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = 4'b0001;
          PCWrite = 1'b1;
        end
        S_DECODE: begin
          ALUSrcB   = 2'b11;
          ALUOp     = 4'b0001;
          IllegalOp = op_illegal;
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = (OP == OP_LW) ? 4'b0110 : 4'b0101;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 4'b1111;
        end
        S_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_I_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (OP)
            OP_ORI:  ALUOp = 4'b0010;
            OP_ANDI: ALUOp = 4'b0011;
            OP_LUI:  ALUOp = 4'b0100;
            default: ALUOp = 4'b0001;
          endcase
        end
        S_I_WB: begin
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          PCSource = 2'b01;
          if (OP == OP_BNE) begin
            ALUOp         = 4'b1000;
            PCWriteCondNE = 1'b1;
          end else begin
            ALUOp       = 4'b0111;
            PCWriteCond = 1'b1;
          end
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_JR: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
          ALUOp    = 4'b1111;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       IRWrite, PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead;
  logic       MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, State;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCWriteCondNE(PCWriteCondNE), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .IllegalOp(IllegalOp),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .State(State)
  );

  // Observed vector layout: flags[11:0] = {IRWrite, PCWrite, PCWriteCond,
  // PCWriteCondNE, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite,
  // ALUSrcA, IllegalOp}, then ALUSrcB, PCSource, ALUOp, State.
  logic [23:0] obs;
  assign obs = {IRWrite, PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead,
                MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp,
                ALUSrcB, PCSource, ALUOp, State};

  function automatic logic [23:0] ev(input logic [11:0] flags, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [3:0] aop,
                                     input logic [3:0] st);
    return {flags, asb, pcs, aop, st};
  endfunction

  // Hand-derived expected outputs per state
  localparam logic [23:0] E_ZERO     = 24'h0;
  localparam logic [23:0] E_FETCH    = {12'b1100_0100_0000, 2'b01, 2'b00, 4'b0001, 4'd0};
  localparam logic [23:0] E_DECODE   = {12'b0000_0000_0000, 2'b11, 2'b00, 4'b0001, 4'd1};
  localparam logic [23:0] E_DEC_ILL  = {12'b0000_0000_0001, 2'b11, 2'b00, 4'b0001, 4'd1};
  localparam logic [23:0] E_MA_LW    = {12'b0000_0000_0010, 2'b10, 2'b00, 4'b0110, 4'd2};
  localparam logic [23:0] E_MA_SW    = {12'b0000_0000_0010, 2'b10, 2'b00, 4'b0101, 4'd2};
  localparam logic [23:0] E_MREAD    = {12'b0000_1100_0000, 2'b00, 2'b00, 4'b0000, 4'd3};
  localparam logic [23:0] E_MWB      = {12'b0000_0001_0100, 2'b00, 2'b00, 4'b0000, 4'd4};
  localparam logic [23:0] E_MWRITE   = {12'b0000_1010_0000, 2'b00, 2'b00, 4'b0000, 4'd5};
  localparam logic [23:0] E_REXEC    = {12'b0000_0000_0010, 2'b00, 2'b00, 4'b1111, 4'd6};
  localparam logic [23:0] E_RWB      = {12'b0000_0000_1100, 2'b00, 2'b00, 4'b0000, 4'd7};
  localparam logic [23:0] E_BEQ      = {12'b0010_0000_0010, 2'b00, 2'b01, 4'b0111, 4'd8};
  localparam logic [23:0] E_BNE      = {12'b0001_0000_0010, 2'b00, 2'b01, 4'b1000, 4'd8};
  localparam logic [23:0] E_JUMP     = {12'b0100_0000_0000, 2'b00, 2'b10, 4'b0000, 4'd9};
  localparam logic [23:0] E_IWB      = {12'b0000_0000_0100, 2'b00, 2'b00, 4'b0000, 4'd11};
  localparam logic [23:0] E_JR       = {12'b0100_0000_0000, 2'b00, 2'b11, 4'b1111, 4'd12};

  task automatic chk(input string tag, input logic [23:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock and check the outputs at the following falling edge.
  task automatic step(input string tag, input logic [23:0] exp);
    @(posedge clk);
    @(negedge clk);
    chk(tag, exp);
  endtask

  // Called while in FETCH; sets the instruction fields for the next DECODE.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn);
    OP    = op;
    Funct = fn;
  endtask

  initial begin
    reset = 1'b1;
    OP    = 6'h00;
    Funct = 6'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", E_ZERO);
    reset = 1'b0;
    #1 chk("fetch_after_reset", E_FETCH);

    // LW: 0,1,2,3,4,0
    issue(6'h23, 6'h00);
    step("lw_decode",   E_DECODE);
    step("lw_mem_addr", E_MA_LW);
    step("lw_mem_read", E_MREAD);
    step("lw_mem_wb",   E_MWB);
    step("lw_fetch",    E_FETCH);

    // SW: 0,1,2,5,0
    issue(6'h2B, 6'h00);
    step("sw_decode",    E_DECODE);
    step("sw_mem_addr",  E_MA_SW);
    step("sw_mem_write", E_MWRITE);
    step("sw_fetch",     E_FETCH);

    // R-type add
    issue(6'h00, 6'h20);
    step("r_decode", E_DECODE);
    step("r_exec",   E_REXEC);
    step("r_wb",     E_RWB);
    step("r_fetch",  E_FETCH);

    // BNE
    issue(6'h05, 6'h00);
    step("bne_decode", E_DECODE);
    step("bne_branch", E_BNE);
    step("bne_fetch",  E_FETCH);

    // BEQ
    issue(6'h04, 6'h00);
    step("beq_decode", E_DECODE);
    step("beq_branch", E_BEQ);
    step("beq_fetch",  E_FETCH);

    // JR
    issue(6'h00, 6'h08);
    step("jr_decode", E_DECODE);
    step("jr_exec",   E_JR);
    step("jr_fetch",  E_FETCH);

    // J
    issue(6'h02, 6'h00);
    step("j_decode", E_DECODE);
    step("j_exec",   E_JUMP);
    step("j_fetch",  E_FETCH);

    // Immediate ops: ADDI, ORI, ANDI, LUI
    issue(6'h08, 6'h00);
    step("addi_decode", E_DECODE);
    step("addi_exec",   ev(12'b0000_0000_0010, 2'b10, 2'b00, 4'b0001, 4'd10));
    step("addi_wb",     E_IWB);
    step("addi_fetch",  E_FETCH);
    issue(6'h0D, 6'h00);
    step("ori_decode", E_DECODE);
    step("ori_exec",   ev(12'b0000_0000_0010, 2'b10, 2'b00, 4'b0010, 4'd10));
    step("ori_wb",     E_IWB);
    step("ori_fetch",  E_FETCH);
    issue(6'h0C, 6'h00);
    step("andi_decode", E_DECODE);
    step("andi_exec",   ev(12'b0000_0000_0010, 2'b10, 2'b00, 4'b0011, 4'd10));
    step("andi_wb",     E_IWB);
    step("andi_fetch",  E_FETCH);
    issue(6'h0F, 6'h00);
    step("lui_decode", E_DECODE);
    step("lui_exec",   ev(12'b0000_0000_0010, 2'b10, 2'b00, 4'b0100, 4'd10));
    step("lui_wb",     E_IWB);
    step("lui_fetch",  E_FETCH);

    // Illegal opcode: IllegalOp only in DECODE, back to FETCH
    issue(6'h3F, 6'h00);
    step("ill_decode", E_DEC_ILL);
    step("ill_fetch",  E_FETCH);
    issue(6'h01, 6'h00);
    step("ill2_decode", E_DEC_ILL);
    step("ill2_fetch",  E_FETCH);

    // LW interrupted by reset in MEM_READ
    issue(6'h23, 6'h00);
    step("lwr_decode",   E_DECODE);
    step("lwr_mem_addr", E_MA_LW);
    step("lwr_mem_read", E_MREAD);
    reset = 1'b1;
    #1 chk("lwr_reset_comb", E_ZERO);
    step("lwr_reset_held", E_ZERO);
    reset = 1'b0;
    #1 chk("lwr_fetch_after", E_FETCH);
    issue(6'h00, 6'h20);
    step("post_r_decode", E_DECODE);
    step("post_r_exec",   E_REXEC);

    // Reset from a mid-instruction state with an illegal opcode on the bus
    reset = 1'b1;
    OP    = 6'h3F;
    step("rst_any_state", E_ZERO);
    reset = 1'b0;
    #1 chk("rst_any_fetch", E_FETCH);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
